// File: rtl/ct_f_spsram_param_pkg.sv
// Shared definitions for the parametrised single-port SRAM model:
// controller state encodings and the segment-count derivation.
package ct_f_spsram_param_pkg;

   // Controller states: zero-fill in progress, or accepting accesses
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   // Number of independently writable segments in one data word
   function automatic int seg_cnt(input int data_width, input int seg_width);
      return data_width / seg_width;
   endfunction

endpackage

// File: rtl/ct_f_spsram_param_ram.sv
// One segment slice of the SRAM array: a plain block RAM with a single
// write enable and a registered read (read-before-write on collision).
module ct_f_spsram_param_ram #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  CLK,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

   // Synchronous write and registered read so the array maps onto block RAM
   always_ff @(posedge CLK) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/ct_f_spsram_param.sv
// Parametrised single-port SRAM model with segment-masked writes, a
// read-valid strobe, read-data holding, optional output register and a
// zero-fill engine that runs after reset and on CLR.
module ct_f_spsram_param
   import ct_f_spsram_param_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 13,
   parameter int SEG_WIDTH  = 8,
   parameter int OUT_REG    = 0,
   parameter int INIT_CLEAR = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CEN,
   input  logic                  GWEN,
   input  logic [DATA_WIDTH-1:0] WEN,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic                  CLR,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  QVLD,
   output logic                  BUSY
);

   localparam int                    SEG_CNT   = seg_cnt(DATA_WIDTH, SEG_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   logic [0:0]            state_reg, state_next;
   logic [ADDR_WIDTH-1:0] clr_cnt_reg, clr_cnt_next;
   logic                  busy;
   logic                  acc;
   logic                  rd_acc;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [DATA_WIDTH-1:0] q_comb;
   logic [DATA_WIDTH-1:0] hold_reg;
   logic                  rd_pend_reg;
   logic                  unused_wen;

   assign busy     = (state_reg == ST_CLEAR);
   assign BUSY     = busy;
   assign acc      = !busy && !CEN;
   assign rd_acc   = acc && GWEN;
   assign ram_addr = busy ? clr_cnt_reg : A;
   // Only the top bit of each WEN segment is meaningful
   assign unused_wen = ^WEN;

   // Next-state logic: walk the clear counter through every address, and
   // restart the fill only when CLR arrives while accesses are open
   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      if (state_reg == ST_CLEAR) begin
         clr_cnt_next = clr_cnt_reg + 1'b1;
         if (clr_cnt_reg == LAST_ADDR) begin
            state_next = ST_READY;
         end
      end else if (CLR) begin
         state_next   = ST_CLEAR;
         clr_cnt_next = '0;
      end
   end

   // Controller state and clear counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
         clr_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   // One RAM slice per segment; during clear every slice writes zero
   generate
      for (genvar gi = 0; gi < SEG_CNT; gi++) begin : g_seg
         logic                 seg_we;
         logic [SEG_WIDTH-1:0] seg_wdata;

         assign seg_we    = busy || (acc && !GWEN && !WEN[gi*SEG_WIDTH+SEG_WIDTH-1]);
         assign seg_wdata = busy ? '0 : D[gi*SEG_WIDTH +: SEG_WIDTH];

         ct_f_spsram_param_ram #(
            .WIDTH      (SEG_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
         ) u_ram (
            .CLK   (CLK),
            .we    (seg_we),
            .addr  (ram_addr),
            .wdata (seg_wdata),
            .rdata (ram_rdata[gi*SEG_WIDTH +: SEG_WIDTH])
         );
      end
   endgenerate

   // RAM output register changes every cycle, so present it only in the
   // cycle after a read and otherwise replay the held word
   assign q_comb = rd_pend_reg ? ram_rdata : hold_reg;

   // Read-pending flag and hold register for the last read word
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_pend_reg <= 1'b0;
         hold_reg    <= '0;
      end else begin
         rd_pend_reg <= rd_acc;
         if (rd_pend_reg) begin
            hold_reg <= ram_rdata;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_WIDTH-1:0] q_out_reg;
         logic                  qvld_out_reg;

         // Extra output stage: delays data and strobe together by one cycle
         always_ff @(posedge CLK) begin
            if (RST) begin
               q_out_reg    <= '0;
               qvld_out_reg <= 1'b0;
            end else begin
               q_out_reg    <= q_comb;
               qvld_out_reg <= rd_pend_reg;
            end
         end

         assign Q    = q_out_reg;
         assign QVLD = qvld_out_reg;
      end else begin : g_noreg
         assign Q    = q_comb;
         assign QVLD = rd_pend_reg;
      end
   endgenerate

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Directed bench: two instances (no output register / with output register)
// share one stimulus stream; 32-bit words, 8-bit segments, 16 addresses.
module tb_ct_f_spsram_param;

   localparam int DW = 32;
   localparam int AW = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          CEN;
   logic          GWEN;
   logic [DW-1:0] WEN;
   logic [AW-1:0] A;
   logic [DW-1:0] D;
   logic          CLR;
   logic [DW-1:0] q0, q1;
   logic          qvld0, qvld1, busy0, busy1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   ct_f_spsram_param #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .SEG_WIDTH (8), .OUT_REG (0), .INIT_CLEAR (1)
   ) u0 (
      .CLK (CLK), .RST (RST), .CEN (CEN), .GWEN (GWEN), .WEN (WEN), .A (A),
      .D (D), .CLR (CLR), .Q (q0), .QVLD (qvld0), .BUSY (busy0)
   );

   ct_f_spsram_param #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .SEG_WIDTH (8), .OUT_REG (1), .INIT_CLEAR (1)
   ) u1 (
      .CLK (CLK), .RST (RST), .CEN (CEN), .GWEN (GWEN), .WEN (WEN), .A (A),
      .D (D), .CLR (CLR), .Q (q1), .QVLD (qvld1), .BUSY (busy1)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      CEN  = 1'b1;
      GWEN = 1'b1;
      WEN  = '1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] w);
      CEN = 1'b0; GWEN = 1'b0; A = a; D = d; WEN = w;
      step();
      idle();
   endtask

   task automatic rd0(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      CEN = 1'b0; GWEN = 1'b1; A = a;
      step();
      idle();
      check_val({tag, "_qvld"}, 32'(qvld0), 32'd1);
      check_val({tag, "_q"}, q0, exp);
   endtask

   // Counts cycles with BUSY high starting at the current cycle (bounded)
   task automatic count_busy(output int n);
      n = 0;
      while (busy0 && n < 100) begin
         n++;
         step();
      end
   endtask

   int nb;

   initial begin
      RST = 1'b1; CLR = 1'b0; A = '0; D = '0;
      idle();
      step(); step(); step();

      // Reset state
      check_val("rst_q0", q0, 32'h0);
      check_val("rst_qvld0", 32'(qvld0), 32'd0);
      check_val("rst_busy0", 32'(busy0), 32'd1);
      check_val("rst_q1", q1, 32'h0);
      check_val("rst_qvld1", 32'(qvld1), 32'd0);

      // Initial zero-fill length
      RST = 1'b0;
      count_busy(nb);
      check_val("init_busy_len", 32'(nb), 32'd16);
      check_val("init_busy1_done", 32'(busy1), 32'd0);

      // Every address reads zero, QVLD only in the cycle after each read
      for (int i = 0; i < 16; i++) begin
         rd0($sformatf("init_rd%0d", i), AW'(i), 32'h0);
         step();
         check_val($sformatf("init_rd%0d_qvld_off", i), 32'(qvld0), 32'd0);
      end

      // Segment-masked write
      wr(4'd3, 32'hFFFF_FFFF, 32'h0000_0000);
      wr(4'd3, 32'h0000_0000, 32'hFFFF_FF00);
      rd0("mask_rd3", 4'd3, 32'hFFFF_FF00);

      // Hold across idle and a write to the last-read address
      wr(4'd5, 32'h0000_00A5, 32'h0);
      rd0("hold_rd5", 4'd5, 32'h0000_00A5);
      for (int i = 0; i < 4; i++) begin
         step();
         check_val($sformatf("hold_idle%0d_q", i), q0, 32'h0000_00A5);
         check_val($sformatf("hold_idle%0d_qvld", i), 32'(qvld0), 32'd0);
      end
      wr(4'd5, 32'h0000_0011, 32'h0);
      check_val("hold_wr_q", q0, 32'h0000_00A5);
      check_val("hold_wr_qvld", 32'(qvld0), 32'd0);
      step();
      check_val("hold_wr2_q", q0, 32'h0000_00A5);

      // Back-to-back reads; u1 lags u0 by one cycle
      wr(4'd1, 32'h0000_0101, 32'h0);
      wr(4'd2, 32'h0000_0202, 32'h0);
      wr(4'd3, 32'h0000_0303, 32'h0);
      CEN = 1'b0; GWEN = 1'b1; A = 4'd1;
      step();                                   // N+1
      A = 4'd2;
      check_val("b2b_n1_q0", q0, 32'h0000_0101);
      check_val("b2b_n1_qvld1", 32'(qvld1), 32'd0);
      step();                                   // N+2
      A = 4'd3;
      check_val("b2b_n2_q0", q0, 32'h0000_0202);
      check_val("b2b_n2_q1", q1, 32'h0000_0101);
      check_val("b2b_n2_qvld1", 32'(qvld1), 32'd1);
      step();                                   // N+3
      idle();
      check_val("b2b_n3_q0", q0, 32'h0000_0303);
      check_val("b2b_n3_q1", q1, 32'h0000_0202);
      check_val("b2b_n3_qvld1", 32'(qvld1), 32'd1);
      step();                                   // N+4
      check_val("b2b_n4_qvld0", 32'(qvld0), 32'd0);
      check_val("b2b_n4_q1", q1, 32'h0000_0303);
      check_val("b2b_n4_qvld1", 32'(qvld1), 32'd1);
      step();                                   // N+5
      check_val("b2b_n5_qvld1", 32'(qvld1), 32'd0);
      check_val("b2b_n5_q1", q1, 32'h0000_0303);

      // CLR with a concurrent read: the read is served, then the fill runs
      wr(4'd7, 32'h0000_0077, 32'h0);
      CLR = 1'b1; CEN = 1'b0; GWEN = 1'b1; A = 4'd5;
      step();
      CLR = 1'b0;
      check_val("clr_busy", 32'(busy0), 32'd1);
      check_val("clr_rd_qvld", 32'(qvld0), 32'd1);
      check_val("clr_rd_q", q0, 32'h0000_0011);
      // Present writes and reads throughout BUSY; all must be ignored
      nb = 0;
      while (busy0 && nb < 100) begin
         if (nb > 0)
            check_val($sformatf("clr_c%0d_qvld", nb), 32'(qvld0), 32'd0);
         CEN = 1'b0; GWEN = nb[0]; A = 4'd2; D = 32'h0000_0BAD; WEN = '0;
         nb++;
         step();
      end
      check_val("clr_busy_len", 32'(nb), 32'd16);
      check_val("clr_hold_q", q0, 32'h0000_0011);
      // Access in the cycle BUSY falls is accepted
      CEN = 1'b0; GWEN = 1'b1; A = 4'd3;
      step();
      idle();
      check_val("clr_first_qvld", 32'(qvld0), 32'd1);
      check_val("clr_first_q", q0, 32'h0);
      rd0("clr_rd7", 4'd7, 32'h0);
      rd0("clr_rd2", 4'd2, 32'h0);

      // RST in the middle of a fill restarts it
      wr(4'd4, 32'h0000_0044, 32'h0);
      rd0("mid_rd4", 4'd4, 32'h0000_0044);
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      for (int i = 0; i < 8; i++) step();
      RST = 1'b1;
      step();
      check_val("mid_rst_q", q0, 32'h0);
      check_val("mid_rst_qvld", 32'(qvld0), 32'd0);
      check_val("mid_rst_busy", 32'(busy0), 32'd1);
      RST = 1'b0;
      count_busy(nb);
      check_val("mid_busy_len", 32'(nb), 32'd16);
      rd0("mid_rd4z", 4'd4, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
